kb_tx_ctrl: RTL
===============

KB_TX_CTRL -- requirements
Module: kb_tx_ctrl

Interface
REQ-001 SHALL have parameter ENTER_CODE, default 8'h5A, PS/2 scan code that triggers CR/LF insertion.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive keyboard bytes while a message request is pending.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port kb_buf_empty  input  1  keyboard code FIFO empty.
REQ-006 SHALL have port key_code  input  8  FIFO head scan code, first-word-fall-through.
REQ-007 SHALL have port ascii_code  input  8  key2ascii conversion of key_code, combinational.
REQ-008 SHALL have port rd_key_code  output  1  one-cycle FIFO pop strobe.
REQ-009 SHALL have port msg_req, msg_last  input  1 each  message source byte valid, last byte of packet.
REQ-010 SHALL have port msg_data  input  8  message byte.
REQ-011 SHALL have port msg_ack  output  1  one-cycle pulse: msg_data consumed.
REQ-012 SHALL have port tx_full  input  1  UART transmit FIFO full.
REQ-013 SHALL have port wr_uart  output  1  one-cycle UART write strobe.
REQ-014 SHALL have port w_data  output  8  UART write byte, registered.

Function
REQ-015 SHALL use FSM states IDLE, KB_POP, KB_CHAR, CR, LF, MSG; plus HEX_HI, HEX_LO, SP when hex echo is enabled.
REQ-016 SHALL assert wr_uart only in a cycle where tx_full=0; a state needing to write waits with wr_uart=0 while tx_full=1.
REQ-017 SHALL, in IDLE, select keyboard if kb_buf_empty=0 and (msg_req=0 or burst count < MAX_BURST), else MSG if msg_req=1, else stay in IDLE.
REQ-018 SHALL, in KB_POP, pulse rd_key_code for exactly one cycle and latch key_code and ascii_code in that same cycle.
REQ-019 SHALL, in KB_CHAR, write the latched ascii byte, then go to CR if the latched code equals ENTER_CODE, else to IDLE.
REQ-020 SHALL write 8'h0D in CR, then 8'h0A in LF, then return to IDLE; CR/LF is never interleaved with message bytes.
REQ-021 SHALL increment a saturating burst counter per keyboard key completed while msg_req=1, and clear it when a message packet ends.
REQ-022 SHALL, in MSG, write msg_data and pulse msg_ack in the same cycle when msg_req=1 and tx_full=0; leave MSG only after the byte with msg_last=1 is acked.
REQ-023 SHALL treat a message packet as atomic: no keyboard bytes are written between its first and last byte.
REQ-024 SHALL hold in MSG with no write while msg_req=0 mid-packet.
REQ-025 SHALL give a key whose FIFO pop coincides with a msg_req assertion priority only per REQ-017; simultaneous kb and msg with burst=0 selects keyboard.
REQ-026 SHALL have one-cycle minimum latency from kb_buf_empty falling to rd_key_code, and one cycle from KB_POP to the earliest wr_uart.

Reset
REQ-027 SHALL, on reset=1, asynchronously force state IDLE, burst count 0, w_data 8'h00, and rd_key_code, wr_uart, msg_ack 0.
REQ-028 SHALL, on reset mid-sequence, abandon pending CR/LF or hex bytes and any partial message; no strobe is asserted in the reset cycle.

Configuration
REQ-029 SHALL, when macro KB_HEX_ECHO_EN is defined, replace the ascii byte in KB_CHAR with three bytes: upper-case hex ASCII of the high nibble, then the low nibble, then 8'h20; ENTER handling still follows.
REQ-030 SHALL, without KB_HEX_ECHO_EN, omit states HEX_HI, HEX_LO, SP and their logic entirely.

Structure
REQ-031 SHALL place the state enumeration and constants ASCII_CR 8'h0D, ASCII_LF 8'h0A, ASCII_SP 8'h20 in shared package kb_ctrl_pkg.
REQ-032 SHALL implement nibble-to-hex-ASCII in sub-module hex_nibble2ascii, instantiated only under KB_HEX_ECHO_EN.

Verification
REQ-033 SHALL cover a single key: FIFO holds 8'h1C, ascii 8'h61 -> one rd_key_code pulse, one wr_uart with w_data 8'h61.
REQ-034 SHALL cover Enter: key 8'h5A, ascii 8'h0D -> writes 8'h0D, 8'h0D, 8'h0A in order.
REQ-035 SHALL cover backpressure: tx_full=1 for 10 cycles during KB_CHAR -> no wr_uart until tx_full=0, then exactly one write.
REQ-036 SHALL cover arbitration: 6 keys queued and a 3-byte message (last on byte 3) raised together -> 4 key bytes, 3 message bytes contiguous, then 2 key bytes.
REQ-037 SHALL cover hex echo with KB_HEX_ECHO_EN: key 8'h1C -> writes 8'h31, 8'h43, 8'h20.
REQ-038 SHALL cover reset asserted between CR and LF -> all outputs 0 and IDLE immediately, with no LF written after release.

Source files
------------

// File: rtl/kb_ctrl_pkg.sv
// rtl/kb_ctrl_pkg.sv - shared states and ASCII constants for kb_tx_ctrl
// KB_HEX_ECHO_EN adds the hex echo states HEX_HI, HEX_LO and SP.
package kb_ctrl_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [3:0] {
    IDLE,
    KB_POP,
    KB_CHAR,
    CR,
    LF,
    MSG
`ifdef KB_HEX_ECHO_EN
    ,
    HEX_HI,
    HEX_LO,
    SP
`endif
  } kb_state_e;

endpackage

// File: rtl/hex_nibble2ascii.sv
// rtl/hex_nibble2ascii.sv - nibble to upper-case hex ASCII character
module hex_nibble2ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/kb_tx_ctrl.sv
// rtl/kb_tx_ctrl.sv - arbitrates keyboard echo and message bytes onto the UART TX FIFO
// KB_HEX_ECHO_EN echoes each scan code as two hex digits plus a space instead of ASCII.
module kb_tx_ctrl
  import kb_ctrl_pkg::*;
#(
  parameter logic [7:0] ENTER_CODE = 8'h5A,
  parameter int         MAX_BURST  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kb_buf_empty,
  input  logic [7:0] key_code,
  input  logic [7:0] ascii_code,
  output logic       rd_key_code,
  input  logic       msg_req,
  input  logic       msg_last,
  input  logic [7:0] msg_data,
  output logic       msg_ack,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data
);

  localparam int            BW        = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  kb_state_e     state, state_next;
  logic [7:0]    code_q;
  logic [BW-1:0] burst_q;
  logic          staged_q;
  logic          kb_sel, key_done, pkt_done, msg_capture;
  logic          wdata_load;
  logic [7:0]    wdata_next;

`ifdef KB_HEX_ECHO_EN
  logic [3:0] hex_nibble;
  logic [7:0] hex_ascii;

  // High nibble comes straight from the FIFO head while popping, low nibble from the latch.
  assign hex_nibble = (state == KB_POP) ? key_code[7:4] : code_q[3:0];

  hex_nibble2ascii u_hex (
    .nibble (hex_nibble),
    .ascii  (hex_ascii)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      code_q   <= 8'h00;
      burst_q  <= '0;
      staged_q <= 1'b0;
      w_data   <= 8'h00;
    end else begin
      state    <= state_next;
      // A message byte is only written once it has sat in w_data for a cycle.
      staged_q <= msg_capture & msg_req;
      if (rd_key_code) code_q <= key_code;
      if (wdata_load)  w_data <= wdata_next;
      if (pkt_done)
        burst_q <= '0;
      else if (key_done && msg_req && (burst_q < BURST_MAX))
        burst_q <= burst_q + BW'(1);
    end
  end

  always_comb begin
    state_next  = state;
    rd_key_code = 1'b0;
    wr_uart     = 1'b0;
    msg_ack     = 1'b0;
    key_done    = 1'b0;
    pkt_done    = 1'b0;
    msg_capture = 1'b0;
    wdata_load  = 1'b0;
    wdata_next  = 8'h00;
    kb_sel      = !kb_buf_empty && (!msg_req || (burst_q < BURST_MAX));

    case (state)
      IDLE: begin
        if (kb_sel) begin
          state_next = KB_POP;
        end else if (msg_req) begin
          state_next  = MSG;
          msg_capture = 1'b1;
          wdata_load  = 1'b1;
          wdata_next  = msg_data;
        end
      end

      KB_POP: begin
        rd_key_code = 1'b1;
        wdata_load  = 1'b1;
`ifdef KB_HEX_ECHO_EN
        state_next  = HEX_HI;
        wdata_next  = hex_ascii;
`else
        state_next  = KB_CHAR;
        wdata_next  = ascii_code;
`endif
      end

`ifdef KB_HEX_ECHO_EN
      HEX_HI: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = HEX_LO;
          wdata_load = 1'b1;
          wdata_next = hex_ascii;
        end
      end

      HEX_LO: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = SP;
          wdata_load = 1'b1;
          wdata_next = ASCII_SP;
        end
      end

      SP: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          if (code_q == ENTER_CODE) begin
            state_next = CR;
            wdata_load = 1'b1;
            wdata_next = ASCII_CR;
          end else begin
            state_next = IDLE;
            key_done   = 1'b1;
          end
        end
      end
`else
      KB_CHAR: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          if (code_q == ENTER_CODE) begin
            state_next = CR;
            wdata_load = 1'b1;
            wdata_next = ASCII_CR;
          end else begin
            state_next = IDLE;
            key_done   = 1'b1;
          end
        end
      end
`endif

      CR: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = LF;
          wdata_load = 1'b1;
          wdata_next = ASCII_LF;
        end
      end

      LF: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = IDLE;
          key_done   = 1'b1;
        end
      end

      MSG: begin
        if (staged_q && msg_req && !tx_full) begin
          wr_uart = 1'b1;
          msg_ack = 1'b1;
          if (msg_last) begin
            state_next = IDLE;
            pkt_done   = 1'b1;
          end
        end else begin
          // Keep sampling the source so a stalled or withdrawn byte is re-staged fresh.
          msg_capture = 1'b1;
          wdata_load  = 1'b1;
          wdata_next  = msg_data;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
